boid_frame_scheduler: RTL and testbench

Sequences the per-frame rebuild of the 1-bit boid display memory. On each VGA end-of-screen pulse it issues a one-cycle clear to the display RAM, then walks the boid processing units one at a time. For each boid it selects its x/y, computes the pixel address y*640+x, and issues a single-pixel write. It replaces the ad-hoc boid_counter logic in the top level and sits between the BPU array, the output tristate select and RAM_resettable.

---
 rtl/boid_frame_scheduler.sv | 138 +++++++++++++
 tb/tb_boid_frame_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boid_frame_scheduler.sv
// Per-frame display rebuild sequencer: clears the 1-bit display RAM, then plots each active boid.
// Optional build macro OVERRUN_RESTART_EN: a frame_start while busy restarts the frame instead of being ignored.
module boid_frame_scheduler #(
    parameter int MAX_BOIDS      = 4,
    parameter int BITS_FOR_BOIDS = (MAX_BOIDS > 1) ? $clog2(MAX_BOIDS) : 1,
    parameter int VIDEO_WIDTH    = 640,
    parameter int VIDEO_HEIGHT   = 480,
    parameter int ADDR_WIDTH     = 19
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      frame_start,
    input  logic [BITS_FOR_BOIDS:0]   boid_count,
    input  logic [9:0]                x_in,
    input  logic [8:0]                y_in,
    output logic [BITS_FOR_BOIDS-1:0] boid_sel,
    output logic                      disp_clear,
    output logic                      disp_we,
    output logic [ADDR_WIDTH-1:0]     disp_addr,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      overrun,
    output logic [7:0]                offscreen_cnt
);

    // state | meaning
    // IDLE  | waiting for frame_start
    // CLEAR | one-cycle display RAM clear, boid index reset
    // FETCH | boid_sel presents boid i, its x/y are sampled at the closing edge
    // WRITE | single-pixel write for boid i (if it was on screen)
    // DONE  | one-cycle frame_done, back to IDLE

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        WRITE,
        DONE
    } state_t;

    localparam int                FULL_W  = (ADDR_WIDTH > 20) ? ADDR_WIDTH : 20;
    localparam int                CNT_W   = BITS_FOR_BOIDS + 1;
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_BOIDS);
    localparam logic [9:0]        X_LIM   = 10'(VIDEO_WIDTH);
    localparam logic [8:0]        Y_LIM   = 9'(VIDEO_HEIGHT);
    localparam logic [FULL_W-1:0] LINE    = FULL_W'(VIDEO_WIDTH);

    state_t                    state_q;
    state_t                    state_d;
    logic                      start_frame;
    logic [CNT_W-1:0]          cnt_q;
    logic [BITS_FOR_BOIDS-1:0] idx_q;
    logic                      we_q;
    logic                      last_boid;
    logic                      on_screen;
    logic [FULL_W-1:0]         full_addr;

    // Product is formed wider than the RAM address so out-of-range boids cannot wrap silently before truncation.
    assign full_addr = FULL_W'(y_in) * LINE + FULL_W'(x_in);
    assign on_screen = (x_in < X_LIM) && (y_in < Y_LIM);
    assign last_boid = ({1'b0, idx_q} == (cnt_q - 1'b1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d     = CLEAR;
                    start_frame = 1'b1;
                end
            end
            CLEAR:   state_d = (cnt_q == '0) ? DONE : FETCH;
            FETCH:   state_d = WRITE;
            WRITE:   state_d = last_boid ? DONE : FETCH;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef OVERRUN_RESTART_EN
        if (frame_start && (state_q != IDLE)) begin
            state_d     = CLEAR;
            start_frame = 1'b1;
        end
`endif
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            we_q          <= 1'b0;
            disp_addr     <= '0;
            offscreen_cnt <= 8'd0;
            overrun       <= 1'b0;
        end else begin
            if (start_frame) begin
                cnt_q         <= (boid_count > MAX_CNT) ? MAX_CNT : boid_count;
                idx_q         <= '0;
                we_q          <= 1'b0;
                offscreen_cnt <= 8'd0;
            end else begin
                case (state_q)
                    FETCH: begin
                        disp_addr <= full_addr[ADDR_WIDTH-1:0];
                        if (on_screen) begin
                            we_q <= 1'b1;
                        end else if (offscreen_cnt != 8'hFF) begin
                            offscreen_cnt <= offscreen_cnt + 8'd1;
                        end
                    end
                    WRITE: begin
                        we_q  <= 1'b0;
                        idx_q <= last_boid ? '0 : idx_q + 1'b1;
                    end
                    default: ;
                endcase
            end
            if (frame_start && (state_q != IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

    assign boid_sel   = idx_q;
    assign disp_we    = we_q;
    assign disp_clear = (state_q == CLEAR);
    assign frame_done = (state_q == DONE);
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_boid_frame_scheduler.sv
// Self-checking bench for boid_frame_scheduler: fixed vector table, corner sequences and randomized frames.
module tb_boid_frame_scheduler;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        frame_start = 1'b0;
    logic [2:0]  boid_count = 3'd0;
    logic [9:0]  x_in;
    logic [8:0]  y_in;
    logic [1:0]  boid_sel;
    logic        disp_clear;
    logic        disp_we;
    logic [18:0] disp_addr;
    logic        busy;
    logic        frame_done;
    logic        overrun;
    logic [7:0]  offscreen_cnt;

    logic [9:0] bx[4];
    logic [8:0] by[4];

    // The bench stands in for the BPU array: boid_sel picks which position is presented.
    assign x_in = bx[boid_sel];
    assign y_in = by[boid_sel];

    boid_frame_scheduler dut (
        .clock        (clock),
        .resetn       (resetn),
        .frame_start  (frame_start),
        .boid_count   (boid_count),
        .x_in         (x_in),
        .y_in         (y_in),
        .boid_sel     (boid_sel),
        .disp_clear   (disp_clear),
        .disp_we      (disp_we),
        .disp_addr    (disp_addr),
        .busy         (busy),
        .frame_done   (frame_done),
        .overrun      (overrun),
        .offscreen_cnt(offscreen_cnt)
    );

    always #10 clock = ~clock;

    typedef struct {
        int               cnt;
        logic [3:0][9:0]  xs;
        logic [3:0][8:0]  ys;
        int               n_writes;
        int               off;
        logic [3:0][18:0] addrs;
    } vec_t;

    vec_t vecs[7];

    int nvec = 0;
    int nmis = 0;

    int cap_addrs[$];
    int exp_q[$];
    int cap_clears, cap_dones, cap_len, cap_b2b, cap_maxsel, cap_timeout, cap_busy_after, cap_off;

    task automatic chk(input string name, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_vec(input int k, input int cnt,
                           input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2, input int x3, input int y3,
                           input int nw, input int off,
                           input int a0, input int a1, input int a2, input int a3);
        vecs[k].cnt = cnt;
        vecs[k].xs[0] = 10'(x0); vecs[k].ys[0] = 9'(y0);
        vecs[k].xs[1] = 10'(x1); vecs[k].ys[1] = 9'(y1);
        vecs[k].xs[2] = 10'(x2); vecs[k].ys[2] = 9'(y2);
        vecs[k].xs[3] = 10'(x3); vecs[k].ys[3] = 9'(y3);
        vecs[k].n_writes = nw;
        vecs[k].off = off;
        vecs[k].addrs[0] = 19'(a0);
        vecs[k].addrs[1] = 19'(a1);
        vecs[k].addrs[2] = 19'(a2);
        vecs[k].addrs[3] = 19'(a3);
    endtask

    task automatic load_vec(input int k);
        for (int i = 0; i < 4; i++) begin
            bx[i] = vecs[k].xs[i];
            by[i] = vecs[k].ys[i];
        end
        boid_count = 3'(vecs[k].cnt);
        exp_q.delete();
        for (int i = 0; i < vecs[k].n_writes; i++) exp_q.push_back(int'(vecs[k].addrs[i]));
    endtask

    // Reference: walk min(count,4) boids, plot on-screen ones at y*640+x, count the rest.
    task automatic model(output int n, output int off);
        n = (int'(boid_count) > 4) ? 4 : int'(boid_count);
        off = 0;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            if (bx[i] < 640 && by[i] < 480) exp_q.push_back(int'(by[i]) * 640 + int'(bx[i]));
            else off++;
        end
    endtask

    // Pulses frame_start and records one walk; pulse_at >= 0 re-pulses frame_start at that walk cycle.
    task automatic run_frame(input int pulse_at);
        bit prev_we;
        bit seen;
        cap_addrs.delete();
        cap_clears = 0; cap_dones = 0; cap_len = 0; cap_b2b = 0; cap_maxsel = 0; cap_timeout = 0;
        @(negedge clock);
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
        prev_we = 1'b0;
        seen = 1'b0;
        for (int j = 0; j < 200; j++) begin
            if (j > 0) @(negedge clock);
            if (disp_clear) cap_clears++;
            if (disp_we) begin
                cap_addrs.push_back(int'(disp_addr));
                if (prev_we) cap_b2b++;
            end
            prev_we = disp_we;
            if (int'(boid_sel) > cap_maxsel) cap_maxsel = int'(boid_sel);
            frame_start = 1'b0;
            if (j == pulse_at) frame_start = 1'b1;
            if (frame_done) begin
                cap_dones++;
                cap_len = j + 1;
                seen = 1'b1;
                break;
            end
        end
        if (!seen) cap_timeout = 1;
        @(negedge clock);
        frame_start = 1'b0;
        cap_busy_after = int'(busy);
        cap_off = int'(offscreen_cnt);
    endtask

    task automatic compare_frame(input string tag, input int n, input int exp_off);
        chk({tag, ".timeout"}, cap_timeout, 0);
        chk({tag, ".clear_pulses"}, cap_clears, 1);
        chk({tag, ".done_pulses"}, cap_dones, 1);
        chk({tag, ".walk_len"}, cap_len, 2 * n + 2);
        chk({tag, ".writes"}, cap_addrs.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++)
            chk($sformatf("%s.addr%0d", tag, k), (k < cap_addrs.size()) ? cap_addrs[k] : -1, exp_q[k]);
        chk({tag, ".offscreen"}, cap_off, exp_off);
        chk({tag, ".back_to_back"}, cap_b2b, 0);
        chk({tag, ".max_sel"}, cap_maxsel, (n > 0) ? n - 1 : 0);
        chk({tag, ".busy_after"}, cap_busy_after, 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0;
        frame_start = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && busy; i++) @(negedge clock);
        chk("drain_idle", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, off, dones, wes, clears;

        set_vec(0, 4, 10,10, 20,5, 639,479, 0,0,     4, 0, 6410, 3220, 307199, 0);
        set_vec(1, 4, 10,10, 700,10, 5,500, 0,0,     2, 2, 6410, 0, 0, 0);
        set_vec(2, 0, 10,10, 20,5, 30,30, 40,40,     0, 0, 0, 0, 0, 0);
        set_vec(3, 7, 1,1, 2,2, 3,3, 4,4,            4, 0, 641, 1282, 1923, 2564);
        set_vec(4, 1, 639,0, 700,0, 0,0, 0,0,        1, 0, 639, 0, 0, 0);
        set_vec(5, 2, 640,0, 0,480, 0,0, 0,0,        0, 2, 0, 0, 0, 0);
        set_vec(6, 3, 1023,511, 0,479, 100,200, 0,0, 2, 1, 306560, 128100, 0, 0);
        for (int i = 0; i < 4; i++) begin
            bx[i] = '0;
            by[i] = '0;
        end

        repeat (2) @(negedge clock);
        chk("rst.busy", busy, 0);
        chk("rst.disp_we", disp_we, 0);
        chk("rst.disp_clear", disp_clear, 0);
        chk("rst.frame_done", frame_done, 0);
        chk("rst.boid_sel", boid_sel, 0);
        chk("rst.disp_addr", disp_addr, 0);
        chk("rst.overrun", overrun, 0);
        chk("rst.offscreen", offscreen_cnt, 0);
        resetn = 1'b1;
        @(negedge clock);

        for (int k = 0; k < 7; k++) begin
            load_vec(k);
            run_frame(-1);
            n = (vecs[k].cnt > 4) ? 4 : vecs[k].cnt;
            compare_frame($sformatf("vec%0d", k), n, vecs[k].off);
            chk($sformatf("vec%0d.overrun", k), overrun, 0);
            repeat (2) @(negedge clock);
        end

        // frame_start re-pulsed during FETCH of boid 2 (walk cycle 5)
        load_vec(0);
        run_frame(5);
`ifdef OVERRUN_RESTART_EN
        chk("ovr.clear_pulses", cap_clears, 2);
        chk("ovr.writes", cap_addrs.size(), 6);
        chk("ovr.done_pulses", cap_dones, 1);
`else
        compare_frame("ovr", 4, 0);
`endif
        chk("ovr.overrun", overrun, 1);
        drain();

        // frame_start coinciding with DONE still flags overrun
        do_reset();
        chk("ovr_done.pre", overrun, 0);
        load_vec(0);
        run_frame(9);
        chk("ovr_done.done_pulses", cap_dones, 1);
        chk("ovr_done.overrun", overrun, 1);
`ifndef OVERRUN_RESTART_EN
        chk("ovr_done.busy_after", cap_busy_after, 0);
`endif
        drain();

        // boid_count change mid-walk is ignored
        load_vec(0);
        fork
            run_frame(-1);
            begin
                repeat (4) @(negedge clock);
                boid_count = 3'd1;
            end
        join
        load_vec(0);
        compare_frame("cnt_change", 4, 0);

        // reset asserted during WRITE of boid 0
        load_vec(0);
        @(negedge clock);
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
        chk("rstw.clear", disp_clear, 1);
        @(negedge clock);
        @(negedge clock);
        chk("rstw.we_before", disp_we, 1);
        #3 resetn = 1'b0;
        #1;
        chk("rstw.we_async", disp_we, 0);
        chk("rstw.busy_async", busy, 0);
        chk("rstw.sel_async", boid_sel, 0);
        chk("rstw.overrun", overrun, 0);
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (frame_done) dones++;
        end
        resetn = 1'b1;
        @(negedge clock);
        if (frame_done) dones++;
        chk("rstw.no_done", dones, 0);
        chk("rstw.busy_after", busy, 0);
        load_vec(0);
        run_frame(-1);
        compare_frame("rstw.next", 4, 0);

        // two frames with frame_start spaced 12 cycles apart
        load_vec(0);
        dones = 0; wes = 0; clears = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (frame_done) dones++;
            if (disp_we) wes++;
            if (disp_clear) clears++;
            frame_start = (c == 0 || c == 12);
        end
        frame_start = 1'b0;
        chk("b2b.done_pulses", dones, 2);
        chk("b2b.writes", wes, 8);
        chk("b2b.clears", clears, 2);
        chk("b2b.overrun", overrun, 0);

        // randomized frames against the reference model
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) != 0) begin
                    bx[i] = 10'($urandom_range(0, 639));
                    by[i] = 9'($urandom_range(0, 479));
                end else begin
                    bx[i] = 10'($urandom_range(0, 1023));
                    by[i] = 9'($urandom_range(0, 511));
                end
            end
            boid_count = 3'($urandom_range(0, 7));
            model(n, off);
            run_frame(-1);
            compare_frame($sformatf("rnd%0d", r), n, off);
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end
        chk("rnd.overrun", overrun, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
